// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Oversampling UART receive front end. It synchronizes the asynchronous rx
//   line, divides the system clock down to an oversample tick, and detects a
//   start bit. For each bit it takes a three-sample majority vote around the
//   bit centre. Each voted bit is presented to a downstream shift register as
//   bit_out with a one-cycle shift strobe. enable frames the whole transfer.
//   Stop and parity values are passed through unchecked.
//
// Parameters
//   CLK_DIV    clock cycles per oversample tick (2..1023)
//   OVS        ticks per bit period (even, 8..32)
//   FRAME_BITS bits per frame including start, data, parity, stop
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   rx         asynchronous serial line, idle high
//   rx_en      receive enable; gates start detection only
//   bit_out    majority-voted bit, serial data for the downstream shifter
//   shift      one-cycle strobe, bit_out valid in the same cycle
//   enable     high while a frame is in progress (START/DATA)
//   frame_done one-cycle pulse after the last shift of a frame
//   start_err  one-cycle pulse when a start bit is rejected
//   busy       high in any state other than IDLE
module uart_rx_sampler #(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned OVS        = 16,
  parameter int unsigned FRAME_BITS = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  input  logic rx_en,
  output logic bit_out,
  output logic shift,
  output logic enable,
  output logic frame_done,
  output logic start_err,
  output logic busy
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW = $clog2(OVS);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SAMP_FIRST  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SAMP_MID    = SW'(OVS / 2);
  localparam logic [SW-1:0] SAMP_VOTE   = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] SAMP_END    = SW'(OVS - 1);
  localparam logic [BW-1:0] BITS_FRAME  = BW'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Synchronizer
  logic rx_meta;
  logic rx_s;

  // Tick divider
  logic [DW-1:0] div_cnt;
  logic          tick;

  // Bit sampling
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] bit_cnt;
  logic          samp_a;
  logic          samp_b;
  logic          vote;
  logic          in_frame;
  logic          samp_tick;
  logic          vote_tick;

  // FSM decisions consumed by the datapath
  logic start_go;
  logic vote_ok;
  logic vote_bad;

  // Registered strobes
  logic shift_q;
  logic start_err_q;

  // ---------------------------------------------------------------------
  // rx synchronizer; flops idle high so reset never looks like a start bit
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Free-running oversample tick
  // ---------------------------------------------------------------------
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sample timing and majority vote. The third sample is the live rx_s on
  // the vote tick, so the vote is ready on that same tick.
  // ---------------------------------------------------------------------
  assign in_frame  = (state == START) || (state == DATA);
  assign samp_tick = tick && in_frame;
  assign vote_tick = samp_tick && (samp_cnt == SAMP_VOTE);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and status outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    vote_ok    = 1'b0;
    vote_bad   = 1'b0;
    enable     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick && !rx_s && rx_en) begin
          state_next = START;
          start_go   = 1'b1;
        end
      end

      START: begin
        enable = 1'b1;
        if (vote_tick) begin
          if (vote) begin
            // False start: no shift, straight back to hunting
            vote_bad   = 1'b1;
            state_next = IDLE;
          end else begin
            vote_ok = 1'b1;
          end
        end else if (samp_tick && (samp_cnt == SAMP_END)) begin
          state_next = DATA;
        end
      end

      DATA: begin
        enable = 1'b1;
        if (vote_tick) begin
          vote_ok = 1'b1;
        end
        // Leave on the final shift cycle itself so enable covers it,
        // without waiting out the rest of the stop bit.
        if (shift_q && (bit_cnt == BITS_FRAME)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sample/bit counters, vote registers and output strobes
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      bit_out     <= 1'b1;
      shift_q     <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      // Strobes fire the cycle after the vote tick, when bit_out is settled
      shift_q     <= vote_ok;
      start_err_q <= vote_bad;

      if (start_go) begin
        samp_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (samp_tick) begin
          samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + 1'b1;
        end
        if (vote_ok) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (samp_tick && (samp_cnt == SAMP_FIRST)) begin
        samp_a <= rx_s;
      end
      if (samp_tick && (samp_cnt == SAMP_MID)) begin
        samp_b <= rx_s;
      end
      if (vote_tick) begin
        bit_out <= vote;
      end
    end
  end

  assign shift     = shift_q;
  assign start_err = start_err_q;

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter CLK_DIV, default 27, clock cycles per oversample tick (range 2..1023).
REQ-002 Parameter OVS, default 16, ticks per bit period (even, 8..32).
REQ-003 Parameter FRAME_BITS, default 11, bits per frame: start, 8 data LSB-first, parity, stop.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 rx  in  1  asynchronous serial line, idle high.
REQ-007 rx_en  in  1  receive enable; gates start detection only.
REQ-008 bit_out  out  1  majority-voted bit value, feeds the downstream shift register's serial data input.
REQ-009 shift  out  1  one-cycle pulse, bit_out valid in the same cycle.
REQ-010 enable  out  1  high while a frame is in progress; feeds the shift register's enable.
REQ-011 frame_done  out  1  one-cycle pulse, downstream frame register holds a complete frame.
REQ-012 start_err  out  1  one-cycle pulse on rejected (false) start bit.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 rx shall pass through a 2-flop synchronizer (flops reset to 1); rx_s denotes its output.
REQ-015 Tick divider shall be free-running, count 0..CLK_DIV-1, and pulse tick for one cycle when the count equals CLK_DIV-1.
REQ-016 FSM states shall be IDLE, START, DATA, DONE.
REQ-017 IDLE: on tick with rx_s=0 and rx_en=1, go to START with sample count 0 and bit count 0; otherwise stay.
REQ-018 The sample counter shall increment per tick in START/DATA and wrap OVS-1 -> 0 at each bit boundary.
REQ-019 rx_s shall be captured on the ticks where sample count equals OVS/2-1, OVS/2 and OVS/2+1; the vote is the majority of the three.
REQ-020 On the OVS/2+1 tick, bit_out shall load the vote, and shift shall assert for exactly the following cycle with bit_out already stable.
REQ-021 START: a vote of 1 shall pulse start_err, suppress shift, and return to IDLE; a vote of 0 shall shift and set bit count to 1.
REQ-022 START shall move to DATA on the OVS-1 tick.
REQ-023 DATA: each vote shall shift and increment bit count; after the shift making bit count = FRAME_BITS, go to DONE without waiting for the bit end.
REQ-024 DONE shall last one cycle, assert frame_done, and then return to IDLE.
REQ-025 enable shall be high in START and DATA only, and shall stay high through the final shift cycle.
REQ-026 Exactly FRAME_BITS shift pulses shall occur per accepted frame, never more; stop and parity values are not checked here.
REQ-027 rx_en deasserting mid-frame shall not abort the frame; it only blocks the next start.
REQ-028 A new start may be detected in IDLE immediately after DONE; the remaining half stop bit is high and is ignored.
REQ-029 Start detection latency shall be 2 synchronizer cycles plus at most CLK_DIV cycles from the rx falling edge.

Reset
REQ-030 On reset: state IDLE, all counters 0, synchronizer flops 1, bit_out=1, and shift, enable, frame_done, start_err, busy all 0.
REQ-031 Reset shall override everything, including mid-frame; no shift or frame_done pulse shall follow it.

Verification (CLK_DIV=4, OVS=16, bit period 64 cycles)
REQ-032 Send 0x55 with even parity (0) and stop bit 1 -> 11 shifts 64 cycles apart, bit_out sequence 0,1,0,1,0,1,0,1,0,0,1, frame_done one cycle after the last shift, downstream frame = 0x4AA.
REQ-033 rx low for 16 cycles, then high -> start_err pulse, zero shifts, enable returns to 0, busy returns to 0.
REQ-034 A single-tick inverted glitch on the centre sample of data bit 3 -> vote unaffected, frame identical to the undisturbed case.
REQ-035 Reset asserted during data bit 5 -> next cycle all outputs at reset values; the following full frame yields exactly 11 shifts and the correct value.
REQ-036 rx_en=0 at the falling edge -> no activity; rx_en dropped mid-frame -> frame completes with frame_done.
REQ-037 Two back-to-back frames (0xA3, 0x0F) with one stop bit each -> two frame_done pulses and 22 shifts total, with no start_err.
